array_table: RTL



---
 rtl/array_table_pkg.sv | 47 ++++
 rtl/array_table_ram.sv | 45 ++++
 rtl/array_table.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/array_table_pkg.sv
// ----------------------------------------------------------------------------
// array_table_pkg
//
// Shared types and helpers for the array_table block.
//   - state_t         : controller states (INIT sweep, IDLE service, SCAN stream)
//   - clog2           : elaboration-time ceiling log2, used to derive AW
//   - default_entry   : one-hot default pattern for a physical entry
//   - phys_index      : logical-to-physical address mapping (optional reversal)
// ----------------------------------------------------------------------------
package array_table_pkg;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        SCAN = 2'd2
    } state_t;

    // Widest entry default_entry can describe; callers cast down to WIDTH.
    localparam int MAX_WIDTH = 1024;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

    // Physical entry p holds a single set bit at (DEPTH-1-p) mod WIDTH, so
    // with reversed addressing logical entry i reads back as 1 << i.
    function automatic logic [MAX_WIDTH-1:0] default_entry(input int p,
                                                           input int depth,
                                                           input int width);
        return MAX_WIDTH'(1) << ((depth - 1 - p) % width);
    endfunction

    function automatic int phys_index(input int addr,
                                      input int depth,
                                      input int reverse);
        return (reverse != 0) ? (depth - 1 - addr) : addr;
    endfunction

endpackage

// File: rtl/array_table_ram.sv
// ----------------------------------------------------------------------------
// array_table_ram
//
// One-write / one-read storage with a synchronous, read-first read port.
// Contents are not reset; the owning controller reloads them after reset.
//
// Ports:
//   clk    in   rising-edge clock
//   we     in   write enable
//   waddr  in   physical write address
//   wdata  in   write data
//   re     in   read enable; rdata only updates on a read
//   raddr  in   physical read address
//   rdata  out  registered read data (old value on same-address write)
// ----------------------------------------------------------------------------
module array_table_ram
    import array_table_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Both ports use non-blocking updates on the same edge, so a read of an
    // address being written returns the value stored before this edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/array_table.sv
// ----------------------------------------------------------------------------
// array_table
//
// DEPTH x WIDTH writable lookup table. After reset the controller sweeps the
// one-hot default pattern into storage (INIT), then services single writes
// and registered reads (IDLE), or streams every entry in logical order on
// request (SCAN). Optional address reversal applies to all three paths.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset; restarts the INIT sweep
//   wr_en       in   write strobe (IDLE only)
//   wr_addr     in   logical write address
//   wr_data     in   write data
//   rd_en       in   read strobe (IDLE only)
//   rd_addr     in   logical read address
//   rd_data     out  read data, one cycle after rd_en, held until next read
//   rd_valid    out  one-cycle pulse marking fresh rd_data
//   scan_start  in   request a full-table scan (IDLE only)
//   scan_data   out  scanned entry
//   scan_valid  out  scan_data valid
//   scan_last   out  high with scan_valid on the final entry
//   busy        out  high whenever the controller is not in IDLE
// ----------------------------------------------------------------------------
module array_table
    import array_table_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int REVERSE = 1,
    localparam int AW     = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    input  logic             scan_start,
    output logic [WIDTH-1:0] scan_data,
    output logic             scan_valid,
    output logic             scan_last,
    output logic             busy
);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    state_t           state;
    logic [AW-1:0]    cnt;

    logic             ram_we;
    logic [AW-1:0]    ram_waddr;
    logic [WIDTH-1:0] ram_wdata;
    logic             ram_re;
    logic [AW-1:0]    ram_raddr;
    logic [WIDTH-1:0] ram_rdata;

    logic             rd_valid_q;
    logic             scan_valid_q;
    logic             scan_last_q;
    logic [WIDTH-1:0] rd_hold;
    logic [WIDTH-1:0] scan_hold;

    logic [AW-1:0]    wr_phys;
    logic [AW-1:0]    rd_phys;
    logic [AW-1:0]    scan_phys;
    logic [WIDTH-1:0] init_data;

    assign wr_phys   = AW'(phys_index(int'(wr_addr), DEPTH, REVERSE));
    assign rd_phys   = AW'(phys_index(int'(rd_addr), DEPTH, REVERSE));
    assign scan_phys = AW'(phys_index(int'(cnt), DEPTH, REVERSE));
    // INIT walks physical addresses directly, so no mapping on this path.
    assign init_data = WIDTH'(default_entry(int'(cnt), DEPTH, WIDTH));

    // Controller: INIT and SCAN both walk cnt from 0 to DEPTH-1 and return
    // to IDLE on the final step. Port strobes only matter in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            case (state)
                INIT: begin
                    cnt <= cnt + AW'(1);
                    if (cnt == LAST_IDX) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end
                IDLE: begin
                    if (scan_start) begin
                        state <= SCAN;
                        cnt   <= '0;
                    end
                end
                SCAN: begin
                    cnt <= cnt + AW'(1);
                    if (cnt == LAST_IDX) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= INIT;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Storage port steering. The single read port is shared between host
    // reads and the scan; the FSM guarantees they never coincide.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = '0;
        ram_wdata = '0;
        ram_re    = 1'b0;
        ram_raddr = '0;
        case (state)
            INIT: begin
                ram_we    = 1'b1;
                ram_waddr = cnt;
                ram_wdata = init_data;
            end
            IDLE: begin
                ram_we    = wr_en;
                ram_waddr = wr_phys;
                ram_wdata = wr_data;
                ram_re    = rd_en;
                ram_raddr = rd_phys;
            end
            SCAN: begin
                ram_re    = 1'b1;
                ram_raddr = scan_phys;
            end
            default: begin
                ram_we = 1'b0;
            end
        endcase
    end

    array_table_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // Valid flags track what the storage read port fetched on the previous
    // edge. The hold registers capture each delivered word so rd_data and
    // scan_data stay stable once the shared read register moves on.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q   <= 1'b0;
            scan_valid_q <= 1'b0;
            scan_last_q  <= 1'b0;
            rd_hold      <= '0;
            scan_hold    <= '0;
        end else begin
            rd_valid_q   <= (state == IDLE) && rd_en;
            scan_valid_q <= (state == SCAN);
            scan_last_q  <= (state == SCAN) && (cnt == LAST_IDX);
            if (rd_valid_q) begin
                rd_hold <= ram_rdata;
            end
            if (scan_valid_q) begin
                scan_hold <= ram_rdata;
            end
        end
    end

    // The fresh word comes straight from the storage register so the read
    // latency stays at one cycle; afterwards the held copy is shown.
    assign rd_data    = rd_valid_q ? ram_rdata : rd_hold;
    assign rd_valid   = rd_valid_q;
    assign scan_data  = scan_valid_q ? ram_rdata : scan_hold;
    assign scan_valid = scan_valid_q;
    assign scan_last  = scan_last_q;
    assign busy       = (state != IDLE);

endmodule
